// File: rtl/fetch_decode_unit_if.sv
// Bus bundle between the sequencer, the program loader and the ALU.
// master: sequencer side (drives opcode/a/b); slave: loader + ALU side.
interface fetch_decode_unit_if #(
    parameter int PC_W = 4
);
    logic            prog_we;
    logic [PC_W-1:0] prog_addr;
    logic [15:0]     prog_data;
    logic [7:0]      alu_result;
    logic            alu_carry;
    logic [2:0]      opcode;
    logic [7:0]      a;
    logic [7:0]      b;

    modport master (
        input  prog_we, prog_addr, prog_data,
        input  alu_result, alu_carry,
        output opcode, a, b
    );

    modport slave (
        output prog_we, prog_addr, prog_data,
        output alu_result, alu_carry,
        input  opcode, a, b
    );
endinterface

// File: rtl/fetch_decode_unit.sv
// Fetch/decode sequencer: program memory, pc, 4x8 register file, flags.
// Ports: clk, rst (async high), start, bus (prog load + ALU), pc, busy,
// halted, zero_flag, carry_flag, dbg_sel/dbg_data register peek.
module fetch_decode_unit #(
    parameter int PC_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    fetch_decode_unit_if.master bus,
    output logic [PC_W-1:0]     pc,
    output logic                busy,
    output logic                halted,
    output logic                zero_flag,
    output logic                carry_flag,
    input  logic [1:0]          dbg_sel,
    output logic [7:0]          dbg_data
);
    localparam int DEPTH = 2 ** PC_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_WB,
        S_HALTED
    } state_t;

    state_t      state;
    logic [15:0] mem [DEPTH];
    logic [15:0] ir;
    logic [7:0]  regs [4];

    logic [1:0]      cls;
    logic [2:0]      op;
    logic [1:0]      rd;
    logic [1:0]      rs1;
    logic [1:0]      rs2;
    logic [7:0]      imm;
    logic [PC_W-1:0] target;
    logic            mem_we;

    assign cls    = ir[15:14];
    assign op     = ir[13:11];
    assign rd     = ir[10:9];
    assign rs1    = ir[8:7];
    assign rs2    = ir[6:5];
    assign imm    = ir[7:0];
    assign target = ir[PC_W-1:0];

    assign busy   = (state == S_FETCH) || (state == S_DECODE) ||
                    (state == S_EXEC)  || (state == S_WB);
    assign halted = (state == S_HALTED);

    assign dbg_data = regs[dbg_sel];

    // Loading is only possible while the core is parked.
    assign mem_we = bus.prog_we && !busy;

    // Program memory survives reset, so it has no reset branch.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[bus.prog_addr] <= bus.prog_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            pc         <= '0;
            ir         <= '0;
            bus.opcode <= '0;
            bus.a      <= '0;
            bus.b      <= '0;
            zero_flag  <= 1'b0;
            carry_flag <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= '0;
            end
        end else begin
            unique case (state)
                S_IDLE, S_HALTED: begin
                    if (start) begin
                        pc    <= '0;
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir    <= mem[pc];
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    unique case (cls)
                        2'b00: begin
                            // Operands latched here so rd may alias rs1/rs2.
                            bus.opcode <= op;
                            bus.a      <= regs[rs1];
                            bus.b      <= regs[rs2];
                            state      <= S_EXEC;
                        end
                        2'b01: begin
                            state <= S_WB;
                        end
                        2'b10: begin
                            pc    <= zero_flag ? target : pc + 1'b1;
                            state <= S_FETCH;
                        end
                        default: begin
                            state <= S_HALTED;
                        end
                    endcase
                end
                S_EXEC: begin
                    state <= S_WB;
                end
                S_WB: begin
                    if (cls == 2'b00) begin
                        regs[rd]   <= bus.alu_result;
                        zero_flag  <= (bus.alu_result == 8'h00);
                        carry_flag <= bus.alu_carry;
                    end else begin
                        regs[rd] <= imm;
                    end
                    pc    <= pc + 1'b1;
                    state <= S_FETCH;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/fetch_decode_unit.md
Name: fetch_decode_unit

Overview:
- Upstream sequencer for the 8-bit ALU datapath (control decode + alu + result register).
- Holds a small loadable program memory, a program counter and a 4x8 register file.
- Fetches and decodes 16-bit instructions, drives opcode/a/b to the ALU, and writes the ALU result and flags back.
- Turns the free-running ALU into a stepping CPU core.

Parameters:
PC_W, 4, program-counter width; program memory depth = 2**PC_W words (legal range 2..8)

Ports:
clk  input  1  clock, rising-edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle pulse; begins execution at pc=0 from IDLE or HALTED
prog_we  input  1  program memory write strobe; honoured only when busy=0
prog_addr  input  PC_W  program memory write address
prog_data  input  16  program memory write data
alu_result  input  8  combinational ALU result
alu_carry  input  1  combinational ALU carry/error
opcode  output  3  ALU operation select, registered
a  output  8  ALU operand A, registered
b  output  8  ALU operand B, registered
pc  output  PC_W  current program counter
busy  output  1  high in FETCH/DECODE/EXEC/WB
halted  output  1  high in HALTED
zero_flag  output  1  last ALU result == 0
carry_flag  output  1  last ALU carry
dbg_sel  input  2  register-file debug read select
dbg_data  output  8  combinational read of r[dbg_sel]

Behaviour:
- Reset (async, rst=1):
  - state=IDLE.
  - pc, opcode, a, b, ir, all four registers, zero_flag and carry_flag = 0.
  - busy=0, halted=0.
  - Program memory is NOT cleared.
- Reset mid-instruction aborts the instruction; nothing is written back.
- Instruction format (ir[15:14] = class):
  - 00 ALU: op=ir[13:11], rd=ir[10:9], rs1=ir[8:7], rs2=ir[6:5].
  - 01 LDI: rd=ir[10:9], imm=ir[7:0].
  - 10 JZ: target=ir[PC_W-1:0].
  - 11 HALT.
  - Unused bits are ignored.
- FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALTED.
- IDLE / HALTED:
  - start=1 -> pc<=0, next state FETCH.
  - prog_we writes mem[prog_addr]<=prog_data.
- FETCH: ir<=mem[pc]; -> DECODE.
- DECODE:
  - ALU: opcode<=op, a<=r[rs1], b<=r[rs2]; -> EXEC.
  - LDI: -> WB.
  - JZ: if zero_flag, pc<=target, else pc<=pc+1; -> FETCH.
  - HALT: -> HALTED; pc holds the HALT address.
- EXEC: one settle cycle; opcode/a/b stay stable at the ALU inputs; -> WB.
- WB:
  - ALU: r[rd]<=alu_result, zero_flag<=(alu_result==0), carry_flag<=alu_carry.
  - LDI: r[rd]<=imm; flags unchanged.
  - Both: pc<=pc+1; -> FETCH.
- Latency in cycles from FETCH entry to next FETCH: ALU 4, LDI 3, JZ 2. A HALT reaches HALTED 2 cycles after FETCH.
- pc+1 wraps modulo 2**PC_W (DEPTH-1 -> 0).
- opcode/a/b hold their last values outside DECODE updates; they are never cleared except by reset.
- rd may equal rs1/rs2: operands are captured in DECODE, so the write-back in WB is safe.
- Ignored inputs:
  - start while busy=1.
  - prog_we while busy=1: the memory is not modified.
- Simultaneous start and prog_we in IDLE: the write is performed and execution starts. The first FETCH sees the new data if prog_addr=0.
- busy = state in {FETCH, DECODE, EXEC, WB}. halted = state==HALTED.

Test Plan:
- Reset: assert rst mid-EXEC -> all outputs 0, state IDLE, dbg_data=0 for all sel. A rerun with start executes the previously loaded program.
- LDI/ADD: load [LDI r0,0x05; LDI r1,0x03; ALU add(000) r2=r0+r1; HALT]; ALU model a+b -> r2=0x08, zero=0, carry=0. HALTED at pc=3 after 3+3+4+2=12 cycles from FETCH.
- Carry/zero: LDI r0,0xFF; LDI r1,0x01; add r2 -> r2=0x00, zero_flag=1, carry_flag=1. Then JZ 6 -> pc=6 next FETCH. With zero=0, JZ falls through to pc+1.
- Operand aliasing: r1=0x04; ALU sub(001) r1=r1-r1 -> opcode=001, a=b=0x04 during EXEC; r1=0x00, zero=1.
- Wrap/ignore: PC_W=4, no HALT, 16 LDI words -> pc wraps 15->0 and execution continues. A prog_we pulse while busy leaves memory unchanged (checked via a later fetch). A start pulse while busy has no effect.
- Div-by-zero: r0=0x09, r1=0x00, ALU div(110) with a model returning 0x00/carry=1 -> r2=0x00, carry_flag=1, zero_flag=1.
